conv3d_filter_bank_acc: RTL and testbench

- Parametrised successor to the fixed 8-channel/16-filter conv3d bank.
- Self-contained. Holds the weights and biases for all FILTER filters internally.
- Consumes a pre-windowed 3x3 stream, one channel per beat. After the last channel of each pixel it emits FILTER fixed-point results in parallel.
- Tracks pixels per image and raises a done pulse. Sits between the line-buffer/window generator and the pooling stage.

---
 rtl/conv3d_filter_bank_acc_if.sv | 41 ++++
 rtl/conv3d_filter_bank_acc.sv | 202 ++++++++++++++++++++
 tb/tb_conv3d_filter_bank_acc.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3d_filter_bank_acc_if.sv
// -----------------------------------------------------------------------------
// conv3d_filter_bank_acc_if
// Groups the kernel-load, window-stream and result signals of the conv3d
// filter bank.
//   master : the surrounding system (window generator, loader, pooling stage)
//   slave  : the filter bank itself
// Signals:
//   kernel_clear     restart weight load and all counters (one-cycle pulse)
//   load_kernel      weight/bias beat valid, word on kernel
//   load_kernel_done level, every weight and bias is loaded
//   win_valid/ready  window beat handshake, 3x3 window on win_data
//   data_out         FILTER parallel results, valid_out pulses with each pixel
//   done_img         pulse alongside the last pixel of an image
//   busy             a pixel is partially accumulated
// -----------------------------------------------------------------------------
interface conv3d_filter_bank_acc_if #(
    parameter int DATA_W = 16,
    parameter int FILTER = 16
);
    logic                       kernel_clear;
    logic                       load_kernel;
    logic [DATA_W-1:0]          kernel;
    logic                       load_kernel_done;
    logic                       win_valid;
    logic                       win_ready;
    logic [9*DATA_W-1:0]        win_data;
    logic [FILTER*DATA_W-1:0]   data_out;
    logic                       valid_out;
    logic                       done_img;
    logic                       busy;

    modport master (
        output kernel_clear, load_kernel, kernel, win_valid, win_data,
        input  load_kernel_done, win_ready, data_out, valid_out, done_img, busy
    );

    modport slave (
        input  kernel_clear, load_kernel, kernel, win_valid, win_data,
        output load_kernel_done, win_ready, data_out, valid_out, done_img, busy
    );
endinterface

// File: rtl/conv3d_filter_bank_acc.sv
// -----------------------------------------------------------------------------
// conv3d_filter_bank_acc
// Multi-channel 3x3 convolution bank. Holds FILTER sets of 9*CHANEL weights
// plus one bias each, consumes one pre-windowed channel per beat and, after
// the last channel of a pixel, emits FILTER saturated fixed-point results in
// parallel. Counts pixels per WIDTH x HEIGHT image and pulses done_img.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     conv3d_filter_bank_acc_if.slave (load, window and result signals)
// Build option:
//   CONV_RELU_EN  when defined, negative saturated results are forced to 0.
// -----------------------------------------------------------------------------
module conv3d_filter_bank_acc #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int CHANEL = 8,
    parameter int FILTER = 16,
    parameter int ACC_W  = 40
) (
    input  logic                    clk,
    input  logic                    resetn,
    conv3d_filter_bank_acc_if.slave bus
);
    localparam int TAPS   = 9 * CHANEL;
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int WIDX_W = $clog2(TAPS + 1);
    localparam int FIDX_W = $clog2(FILTER + 1);
    localparam int CH_W   = $clog2(CHANEL + 1);
    localparam int PIX_W  = $clog2(NPIX + 1);

    localparam logic [WIDX_W-1:0] BIAS_IDX = WIDX_W'(TAPS);
    localparam logic [FIDX_W-1:0] LAST_F   = FIDX_W'(FILTER - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(CHANEL - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(NPIX - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Nine full-width signed products, each sign-extended into the accumulator
    // width; overflow wraps.
    function automatic logic signed [ACC_W-1:0] mac9(input logic [9*DATA_W-1:0] win,
                                                     input logic [9*DATA_W-1:0] wts);
        logic signed [ACC_W-1:0]    s;
        logic signed [2*DATA_W-1:0] p;
        s = '0;
        for (int k = 0; k < 9; k++) begin
            p = $signed(win[k*DATA_W +: DATA_W]) * $signed(wts[k*DATA_W +: DATA_W]);
            s = s + ACC_W'(p);
        end
        return s;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] post_sat(input logic signed [DATA_W-1:0] v);
`ifdef CONV_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    logic [9*DATA_W-1:0]      weight_q [FILTER][CHANEL];
    logic [9*DATA_W-1:0]      weight_d [FILTER][CHANEL];
    logic signed [DATA_W-1:0] bias_q [FILTER];
    logic signed [DATA_W-1:0] bias_d [FILTER];
    logic signed [ACC_W-1:0]  acc_q [FILTER];
    logic signed [ACC_W-1:0]  acc_d [FILTER];
    logic [WIDX_W-1:0]        widx_q, widx_d;
    logic [FIDX_W-1:0]        fidx_q, fidx_d;
    logic                     load_done_q, load_done_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [PIX_W-1:0]         pix_q, pix_d;
    logic [FILTER*DATA_W-1:0] data_out_q, data_out_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;

    logic [9*DATA_W-1:0]      w_row [FILTER];
    logic signed [ACC_W-1:0]  acc_new [FILTER];
    logic signed [ACC_W-1:0]  total [FILTER];
    logic signed [DATA_W-1:0] result [FILTER];
    logic                     accept_w, accept_px, last_ch;

    // A clear pulse overrides any beat offered in the same cycle.
    assign accept_w  = bus.load_kernel & ~load_done_q & ~bus.kernel_clear;
    assign accept_px = bus.win_valid & load_done_q & ~bus.kernel_clear;
    assign last_ch   = (ch_q == LAST_CH);

    // Datapath: select the current channel's weights, accumulate, and on the
    // last channel align the bias to the product scale (2*FRAC fractional
    // bits) before shifting back to FRAC bits.
    always_comb begin
        for (int f = 0; f < FILTER; f++) begin
            w_row[f] = '0;
            for (int c = 0; c < CHANEL; c++)
                if (ch_q == CH_W'(c)) w_row[f] = weight_q[f][c];
            acc_new[f] = ((ch_q == '0) ? '0 : acc_q[f]) + mac9(bus.win_data, w_row[f]);
            total[f]   = acc_new[f] + (ACC_W'(bias_q[f]) <<< FRAC);
            result[f]  = post_sat(saturate(total[f] >>> FRAC));
        end
    end

    always_comb begin
        weight_d    = weight_q;
        bias_d      = bias_q;
        acc_d       = acc_q;
        widx_d      = widx_q;
        fidx_d      = fidx_q;
        load_done_d = load_done_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        if (bus.kernel_clear) begin
            widx_d      = '0;
            fidx_d      = '0;
            load_done_d = 1'b0;
            ch_d        = '0;
            pix_d       = '0;
            acc_d       = '{default: '0};
        end else begin
            if (accept_w) begin
                // Each filter takes 9*CHANEL weights then its bias.
                if (widx_q == BIAS_IDX) begin
                    for (int f = 0; f < FILTER; f++)
                        if (fidx_q == FIDX_W'(f)) bias_d[f] = bus.kernel;
                    widx_d = '0;
                    if (fidx_q == LAST_F) load_done_d = 1'b1;
                    else                  fidx_d = fidx_q + 1'b1;
                end else begin
                    for (int f = 0; f < FILTER; f++)
                        for (int c = 0; c < CHANEL; c++)
                            for (int k = 0; k < 9; k++)
                                if (fidx_q == FIDX_W'(f) && widx_q == WIDX_W'(c*9 + k))
                                    weight_d[f][c][k*DATA_W +: DATA_W] = bus.kernel;
                    widx_d = widx_q + 1'b1;
                end
            end
            if (accept_px) begin
                acc_d = acc_new;
                if (last_ch) begin
                    ch_d    = '0;
                    valid_d = 1'b1;
                    // pix advances together with the registered result, so
                    // done_img lines up with the pixel that closes the image.
                    done_d  = (pix_q == LAST_PIX);
                    pix_d   = (pix_q == LAST_PIX) ? '0 : pix_q + 1'b1;
                    for (int f = 0; f < FILTER; f++)
                        data_out_d[f*DATA_W +: DATA_W] = result[f];
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            weight_q    <= '{default: '0};
            bias_q      <= '{default: '0};
            acc_q       <= '{default: '0};
            widx_q      <= '0;
            fidx_q      <= '0;
            load_done_q <= 1'b0;
            ch_q        <= '0;
            pix_q       <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            weight_q    <= weight_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            widx_q      <= widx_d;
            fidx_q      <= fidx_d;
            load_done_q <= load_done_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.load_kernel_done = load_done_q;
    assign bus.win_ready        = load_done_q & ~bus.kernel_clear;
    assign bus.data_out         = data_out_q;
    assign bus.valid_out        = valid_q;
    assign bus.done_img         = done_q;
    assign bus.busy             = (ch_q != '0);
endmodule

// File: tb/tb_conv3d_filter_bank_acc.sv
// -----------------------------------------------------------------------------
// tb_conv3d_filter_bank_acc
// Bench for conv3d_filter_bank_acc with CHANEL=2, FILTER=2, WIDTH=HEIGHT=2.
// Directed table vectors with unit weights, saturation and clear/reload
// sequences, a random stream against an integer reference model, and a
// stalled-pixel sequence.
// -----------------------------------------------------------------------------
module tb_conv3d_filter_bank_acc;
    localparam int DW   = 16;
    localparam int FR   = 8;
    localparam int WD   = 2;
    localparam int HT   = 2;
    localparam int CH   = 2;
    localparam int FI   = 2;
    localparam int NPIX = WD * HT;
    localparam int NB   = FI * (9 * CH + 1);

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    conv3d_filter_bank_acc_if #(.DATA_W(DW), .FILTER(FI)) bus ();

    conv3d_filter_bank_acc #(
        .DATA_W(DW), .FRAC(FR), .WIDTH(WD), .HEIGHT(HT),
        .CHANEL(CH), .FILTER(FI), .ACC_W(40)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: weights, biases and the current pixel's windows as
    // plain signed integers.
    int wt [FI][CH][9];
    int bs [FI];
    int pw [CH][9];

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] f0;
        logic [DW-1:0] f1;
    } vec_t;
    vec_t tbl [6];

    logic [FI*DW-1:0] oq_d [$];
    logic             oq_done [$];
    logic [FI*DW-1:0] eq_d [$];
    logic             eq_done [$];

    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            oq_d.push_back(bus.data_out);
            oq_done.push_back(bus.done_img);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Exact real-valued result floored to FR fractional bits, then clamped.
    function automatic logic [DW-1:0] model_out(input int f);
        longint s;
        s = 0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 9; k++)
                s += longint'(pw[c][k]) * longint'(wt[f][c][k]);
        s += longint'(bs[f]) * (longint'(1) << FR);
        s = s >>> FR;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return DW'(s);
    endfunction

    function automatic logic [FI*DW-1:0] model_vec();
        logic [FI*DW-1:0] v;
        for (int f = 0; f < FI; f++) v[f*DW +: DW] = model_out(f);
        return v;
    endfunction

    function automatic logic [9*DW-1:0] pack_win(input int c);
        logic [9*DW-1:0] v;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(pw[c][k]);
        return v;
    endfunction

    function automatic int rnd_word(input int big);
        logic signed [DW-1:0] r;
        if (big != 0) r = DW'($urandom);
        else          r = DW'($urandom_range(0, 2047)) - DW'(1024);
        return int'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.kernel_clear = 1'b0;
        bus.load_kernel  = 1'b0;
        bus.kernel       = '0;
        bus.win_valid    = 1'b0;
        bus.win_data     = '0;
    endtask

    task automatic load_all();
        int n;
        n = 0;
        for (int f = 0; f < FI; f++) begin
            for (int i = 0; i <= 9 * CH; i++) begin
                bus.load_kernel = 1'b1;
                bus.kernel = (i < 9 * CH) ? DW'(wt[f][i / 9][i % 9]) : DW'(bs[f]);
                n++;
                if (n == 5) begin
                    @(negedge clk);
                    chk("win_ready_during_load", bus.win_ready, 1'b0);
                end
                if (n == NB) begin
                    @(negedge clk);
                    chk("load_done_before_last_beat", bus.load_kernel_done, 1'b0);
                end
                tick();
            end
        end
        bus.load_kernel = 1'b0;
        @(negedge clk);
        chk("load_done_after_last_beat", bus.load_kernel_done, 1'b1);
        chk("win_ready_after_load", bus.win_ready, 1'b1);
    endtask

    // Presents all channels of pw; optional stall after the first channel.
    // Returns just after the edge that accepts the last channel.
    task automatic run_pixel(input int gap);
        for (int c = 0; c < CH; c++) begin
            bus.win_valid = 1'b1;
            bus.win_data  = pack_win(c);
            tick();
            if (c == 0 && gap > 0) begin
                bus.win_valid = 1'b0;
                bus.win_data  = {9*DW{1'b1}};
                repeat (gap) begin
                    @(negedge clk);
                    chk("gap_busy", bus.busy, 1'b1);
                    chk("gap_no_valid", bus.valid_out, 1'b0);
                    tick();
                end
            end
        end
        bus.win_valid = 1'b0;
    endtask

    task automatic fill_uniform(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int k = 0; k < 9; k++) begin
            pw[0][k] = int'($signed(a));
            pw[1][k] = int'($signed(b));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        logic [FI*DW-1:0] e;
        logic [DW-1:0]    neg_sat;

        // Unit weights: result = 9*(a+b) + bias in Q8.8.
        tbl[0] = '{16'h0100, 16'h0100, 16'h1200, 16'h1180};
        tbl[1] = '{16'h0080, 16'h0040, 16'h06C0, 16'h0640};
        tbl[2] = '{16'h7F00, 16'h7F00, 16'h7FFF, 16'h7FFF};
`ifdef CONV_RELU_EN
        tbl[3] = '{16'hFF00, 16'hFF00, 16'h0000, 16'h0000};
        tbl[4] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        neg_sat = 16'h0000;
`else
        tbl[3] = '{16'hFF00, 16'hFF00, 16'hEE00, 16'hED80};
        tbl[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'hFF80};
        neg_sat = 16'h8000;
`endif

        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load_done", bus.load_kernel_done, 1'b0);
        chk("rst_win_ready", bus.win_ready, 1'b0);
        chk("rst_valid_out", bus.valid_out, 1'b0);
        chk("rst_done_img", bus.done_img, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_data_out", bus.data_out, '0);
        resetn = 1'b1;
        tick();

        // Unit weights, bias 0 and -0.5.
        for (int f = 0; f < FI; f++)
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < 9; k++) wt[f][c][k] = 256;
        bs[0] = 0;
        bs[1] = -128;
        load_all();

        // A surplus beat after completion must leave every weight untouched.
        bus.load_kernel = 1'b1;
        bus.kernel      = 16'h7FFF;
        tick();
        bus.load_kernel = 1'b0;
        @(negedge clk);
        chk("load_done_holds", bus.load_kernel_done, 1'b1);

        for (int i = 0; i < 6; i++) begin
            fill_uniform(tbl[i].a, tbl[i].b);
            run_pixel(0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), bus.valid_out, 1'b1);
            chk($sformatf("tbl%0d_f0", i), bus.data_out[0 +: DW], tbl[i].f0);
            chk($sformatf("tbl%0d_f1", i), bus.data_out[DW +: DW], tbl[i].f1);
            chk($sformatf("tbl%0d_done", i), bus.done_img, logic'((i % NPIX) == NPIX - 1));
            if (i == 0) begin
                @(negedge clk);
                chk("valid_is_pulse", bus.valid_out, 1'b0);
                chk("data_out_holds", bus.data_out[0 +: DW], 16'h1200);
            end
        end

        // Clear in the middle of a pixel with a load beat offered alongside.
        fill_uniform(16'h0100, 16'h0100);
        bus.win_valid = 1'b1;
        bus.win_data  = pack_win(0);
        tick();
        bus.win_valid = 1'b0;
        @(negedge clk);
        chk("mid_pixel_busy", bus.busy, 1'b1);
        bus.kernel_clear = 1'b1;
        bus.load_kernel  = 1'b1;
        bus.kernel       = 16'h1234;
        bus.win_valid    = 1'b1;
        @(negedge clk);
        chk("clear_blocks_ready", bus.win_ready, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("clear_load_done", bus.load_kernel_done, 1'b0);
        chk("clear_busy", bus.busy, 1'b0);
        chk("clear_valid", bus.valid_out, 1'b0);

        // Reload with 127.0 weights; four pixels must close a fresh image.
        for (int f = 0; f < FI; f++)
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < 9; k++) wt[f][c][k] = 32512;
        bs[0] = 0;
        bs[1] = 0;
        load_all();
        for (int p = 0; p < NPIX; p++) begin
            if (p % 2 == 0) fill_uniform(16'h7F00, 16'h7F00);
            else            fill_uniform(16'h8100, 16'h8100);
            run_pixel(0);
            @(negedge clk);
            chk($sformatf("sat%0d_f0", p), bus.data_out[0 +: DW], (p % 2 == 0) ? 16'h7FFF : neg_sat);
            chk($sformatf("sat%0d_f1", p), bus.data_out[DW +: DW], (p % 2 == 0) ? 16'h7FFF : neg_sat);
            chk($sformatf("sat%0d_done", p), bus.done_img, logic'(p == NPIX - 1));
        end

        // Random weights and a back-to-back stream of four images.
        bus.kernel_clear = 1'b1;
        tick();
        bus.kernel_clear = 1'b0;
        for (int f = 0; f < FI; f++) begin
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < 9; k++) wt[f][c][k] = rnd_word(0);
            bs[f] = rnd_word(0);
        end
        load_all();
        oq_d.delete();
        oq_done.delete();
        for (int p = 0; p < 4 * NPIX; p++) begin
            int big;
            big = ($urandom_range(0, 3) == 0) ? 1 : 0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < 9; k++) pw[c][k] = rnd_word(big);
            eq_d.push_back(model_vec());
            eq_done.push_back(logic'((p % NPIX) == NPIX - 1));
            run_pixel(0);
        end
        repeat (3) tick();
        chk("stream_count", oq_d.size(), eq_d.size());
        for (int i = 0; i < eq_d.size() && i < oq_d.size(); i++) begin
            chk($sformatf("stream%0d_data", i), oq_d[i], eq_d[i]);
            chk($sformatf("stream%0d_done", i), oq_done[i], eq_done[i]);
        end

        // Same pixel without and with a three-cycle stall after channel 0.
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 9; k++) pw[c][k] = rnd_word(0);
        e = model_vec();
        run_pixel(0);
        @(negedge clk);
        chk("nogap_data", bus.data_out, e);
        run_pixel(3);
        @(negedge clk);
        chk("gap_valid", bus.valid_out, 1'b1);
        chk("gap_data", bus.data_out, e);
        chk("gap_done", bus.done_img, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
